board_reset_painter: RTL and testbench
======================================

// Module: board_reset_painter
// PURPOSE
//  Repaints every stepping box of every player lane to the reset colour at game restart.
//  Streams one pixel per accepted beat (x, y, colour, plot) into the VGA plot path
//  under a plot/ready handshake, then pulses done. Successor to the single-pixel,
//  two-lane reset sequencer: player count, box size, lane pitch and colour are parametrised.
// PARAMETERS
//  NUM_PLAYERS   2       player lanes, lane p x-offset = p*LANE_PITCH
//  LANE_PITCH    80      x distance between lanes (pixels)
//  LEFT_X        38      x of left box column, lane 0
//  RIGHT_X       43      x of right box column, lane 0
//  BOX_W         1       box width in pixels (1..4)
//  BOX_H         1       box height in pixels (1..4)
//  RESET_COLOUR  3'b111  colour written to every box pixel
// PORTS
//  clk     in   1  system clock
//  reset   in   1  synchronous, active-high reset
//  start   in   1  level request; a rising level in IDLE starts a repaint
//  ready   in   1  plot path accepts the current pixel this cycle
//  plot    out  1  current x/y/colour valid
//  x       out  8  pixel x
//  y       out  7  pixel y
//  colour  out  3  pixel colour
//  busy    out  1  high from first plot cycle through last accepted pixel
//  done    out  1  one-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset: state=IDLE; plot=0, x=0, y=0, colour=0, busy=0, done=0; all counters 0.
//  Row tables (fixed, in order): LEFT 17 entries {4,13,19,22,25,31,37,49,58,61,67,76,82,85,88,94,97};
//   RIGHT 16 entries {7,10,16,28,34,40,43,46,52,55,64,70,73,79,91,100}.
//  Scan order: player p (0..N-1) > column (LEFT then RIGHT) > table index ascending >
//   dy (0..BOX_H-1) > dx (0..BOX_W-1). Pixel = (colX + p*LANE_PITCH + dx, row + dy).
//  Total beats = NUM_PLAYERS*33*BOX_W*BOX_H (594 for 2 players, 3x3 boxes; 66 at 1x1).
//  States: IDLE -> PAINT -> DONE -> HOLD -> IDLE.
//   IDLE : start=1 sampled at edge k -> PAINT; first pixel presented cycle k+1.
//   PAINT: plot=1, colour=RESET_COLOUR, busy=1. Beat completes when plot&ready at an edge;
//          then next pixel appears next cycle. ready=0 holds x/y/colour stable, no advance.
//          Last beat accepted -> DONE.
//   DONE : plot=0, busy=0, done=1 for exactly one cycle -> HOLD.
//   HOLD : wait until start=0 -> IDLE (start held high never triggers a second repaint).
//  All outputs registered; colour=0 and x,y hold last value whenever plot=0.
//  start toggling during PAINT/DONE ignored. No accept while ready=0 for any duration.
//  reset mid-PAINT: next cycle plot=0, busy=0, no done pulse, state IDLE; next start restarts
//   from p=0, LEFT, index 0, dx=dy=0.
//  Width rule: elaboration error if RIGHT_X+(NUM_PLAYERS-1)*LANE_PITCH+BOX_W-1 > 255
//   or 100+BOX_H-1 > 127. Counters sized by $clog2; no wrap inside a repaint.
// TESTING
//  1 defaults, ready=1, start pulse -> 66 beats; beat0 (38,4), beat16 (38,97), beat17 (43,7),
//    beat33 (118,4), beat65 (123,100); colour=7 each; done one cycle after beat65.
//  2 random ready (~50% duty) -> identical 66-beat sequence, x/y stable while ready=0, no dup/skip.
//  3 BOX_W=3,BOX_H=3 -> 594 beats; first 9 = (38..40, 4..6) row-major; last (125,102).
//  4 start held high 200 cycles -> exactly one repaint, one done; drop start then raise -> second repaint.
//  5 reset asserted at beat 20 -> plot=0 next cycle, no done; restart begins at (38,4).
//  6 NUM_PLAYERS=3 -> 99 beats, third lane starts (198,4), ends (203,100).

Source files
------------

// File: rtl/board_reset_painter_if.sv
//------------------------------------------------------------------------------
// Module   : board_reset_painter_if
// Purpose  : Start/status and VGA plot-path handshake bundle for the board reset painter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface board_reset_painter_if;
  logic       start;
  logic       ready;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  modport master (
    input  start, ready,
    output plot, x, y, colour, busy, done
  );

  modport slave (
    output start, ready,
    input  plot, x, y, colour, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/board_reset_painter.sv
//------------------------------------------------------------------------------
// Module   : board_reset_painter
// Purpose  : Streams every stepping-box pixel of every player lane in the reset colour.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module board_reset_painter #(
  parameter int         NUM_PLAYERS  = 2,
  parameter int         LANE_PITCH   = 80,
  parameter int         LEFT_X       = 38,
  parameter int         RIGHT_X      = 43,
  parameter int         BOX_W        = 1,
  parameter int         BOX_H        = 1,
  parameter logic [2:0] RESET_COLOUR = 3'b111
) (
  input  wire logic               clk,
  input  wire logic               reset,
  board_reset_painter_if.master   bus
);

  localparam int PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  generate
    if ((RIGHT_X + (NUM_PLAYERS - 1) * LANE_PITCH + BOX_W - 1 > 255) ||
        (100 + BOX_H - 1 > 127) ||
        (BOX_W < 1) || (BOX_W > 4) || (BOX_H < 1) || (BOX_H > 4) ||
        (NUM_PLAYERS < 1)) begin : g_width_check
      $error("board_reset_painter: geometry does not fit the 8-bit x / 7-bit y plot space");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAINT = 2'd1,
    S_DONE  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_p;
  logic             r_col;
  logic [4:0]       r_idx;
  logic [DYW-1:0]   r_dy;
  logic [DXW-1:0]   r_dx;

  logic [PW-1:0]    w_p;
  logic             w_col;
  logic [4:0]       w_idx;
  logic [DYW-1:0]   w_dy;
  logic [DXW-1:0]   w_dx;
  logic             w_last;
  logic [7:0]       w_x;
  logic [6:0]       w_y;

  function automatic logic [6:0] row_of(input logic col, input logic [4:0] idx);
    logic [6:0] r;
    r = 7'd0;
    if (!col) begin
      case (idx)
        5'd0:  r = 7'd4;   5'd1:  r = 7'd13;  5'd2:  r = 7'd19;  5'd3:  r = 7'd22;
        5'd4:  r = 7'd25;  5'd5:  r = 7'd31;  5'd6:  r = 7'd37;  5'd7:  r = 7'd49;
        5'd8:  r = 7'd58;  5'd9:  r = 7'd61;  5'd10: r = 7'd67;  5'd11: r = 7'd76;
        5'd12: r = 7'd82;  5'd13: r = 7'd85;  5'd14: r = 7'd88;  5'd15: r = 7'd94;
        5'd16: r = 7'd97;
        default: r = 7'd0;
      endcase
    end else begin
      case (idx)
        5'd0:  r = 7'd7;   5'd1:  r = 7'd10;  5'd2:  r = 7'd16;  5'd3:  r = 7'd28;
        5'd4:  r = 7'd34;  5'd5:  r = 7'd40;  5'd6:  r = 7'd43;  5'd7:  r = 7'd46;
        5'd8:  r = 7'd52;  5'd9:  r = 7'd55;  5'd10: r = 7'd64;  5'd11: r = 7'd70;
        5'd12: r = 7'd73;  5'd13: r = 7'd79;  5'd14: r = 7'd91;  5'd15: r = 7'd100;
        default: r = 7'd0;
      endcase
    end
    return r;
  endfunction

  // Next scan position: the successor of the current beat while painting,
  // otherwise the origin so a fresh start always begins at lane 0, LEFT, index 0.
  always_comb begin
    logic dx_last, dy_last, idx_last, p_last;
    dx_last  = (r_dx == DXW'(BOX_W - 1));
    dy_last  = (r_dy == DYW'(BOX_H - 1));
    idx_last = r_col ? (r_idx == 5'd15) : (r_idx == 5'd16);
    p_last   = (r_p == PW'(NUM_PLAYERS - 1));
    w_last   = dx_last && dy_last && idx_last && r_col && p_last;

    w_p   = r_p;
    w_col = r_col;
    w_idx = r_idx;
    w_dy  = r_dy;
    w_dx  = r_dx;
    if (!dx_last) begin
      w_dx = r_dx + 1'b1;
    end else begin
      w_dx = '0;
      if (!dy_last) begin
        w_dy = r_dy + 1'b1;
      end else begin
        w_dy = '0;
        if (!idx_last) begin
          w_idx = r_idx + 1'b1;
        end else begin
          w_idx = '0;
          if (!r_col) begin
            w_col = 1'b1;
          end else begin
            w_col = 1'b0;
            w_p   = r_p + 1'b1;
          end
        end
      end
    end

    if (r_state != S_PAINT) begin
      w_p   = '0;
      w_col = 1'b0;
      w_idx = '0;
      w_dy  = '0;
      w_dx  = '0;
    end

    w_x = 8'((w_col ? RIGHT_X : LEFT_X) + int'(w_p) * LANE_PITCH + int'(w_dx));
    w_y = 7'(int'(row_of(w_col, w_idx)) + int'(w_dy));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_col      <= 1'b0;
      r_idx      <= '0;
      r_dy       <= '0;
      r_dx       <= '0;
      bus.plot   <= 1'b0;
      bus.x      <= 8'd0;
      bus.y      <= 7'd0;
      bus.colour <= 3'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_PAINT;
            r_p        <= w_p;
            r_col      <= w_col;
            r_idx      <= w_idx;
            r_dy       <= w_dy;
            r_dx       <= w_dx;
            bus.plot   <= 1'b1;
            bus.x      <= w_x;
            bus.y      <= w_y;
            bus.colour <= RESET_COLOUR;
            bus.busy   <= 1'b1;
          end
        end
        S_PAINT: begin
          if (bus.ready) begin
            if (w_last) begin
              r_state    <= S_DONE;
              bus.plot   <= 1'b0;
              bus.colour <= 3'd0;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
            end else begin
              r_p   <= w_p;
              r_col <= w_col;
              r_idx <= w_idx;
              r_dy  <= w_dy;
              r_dx  <= w_dx;
              bus.x <= w_x;
              bus.y <= w_y;
            end
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          // A level held high must be released before the next repaint can start.
          if (!bus.start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_board_reset_painter.sv
//------------------------------------------------------------------------------
// Module   : tb_board_reset_painter
// Purpose  : Self-checking bench for board_reset_painter (three geometries).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_board_reset_painter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  board_reset_painter_if if0 ();
  board_reset_painter_if if1 ();
  board_reset_painter_if if2 ();

  board_reset_painter u0 (.clk(clk), .reset(reset), .bus(if0));
  board_reset_painter #(.BOX_W(3), .BOX_H(3)) u1 (.clk(clk), .reset(reset), .bus(if1));
  board_reset_painter #(.NUM_PLAYERS(3)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int n_tests = 0;
  int n_fail  = 0;

  int left_rows [17] = '{4, 13, 19, 22, 25, 31, 37, 49, 58, 61, 67, 76, 82, 85, 88, 94, 97};
  int right_rows[16] = '{7, 10, 16, 28, 34, 40, 43, 46, 52, 55, 64, 70, 73, 79, 91, 100};

  int q   [3][$];
  int acc [3][$];
  int done_cnt    [3];
  int done_cyc    [3];
  int last_acc    [3];
  bit have_hold   [3];
  int hold_pix    [3];

  typedef struct {
    int beat;
    int x;
    int y;
  } vec_t;
  vec_t tbl [5];

  function automatic int pix(input int x, input int y);
    return x * 1000 + y;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic plot, input logic ready, input logic busy,
                     input logic done, input logic [7:0] x, input logic [6:0] y,
                     input logic [2:0] colour);
    int p;
    if (reset) begin
      have_hold[d] = 1'b0;
      return;
    end
    p = pix(int'(x), int'(y));
    if (plot || busy) check($sformatf("dut%0d busy", d), 32'(busy), 32'(plot));
    if (!plot) check($sformatf("dut%0d idle colour", d), 32'(colour), 0);
    if (plot && have_hold[d]) check($sformatf("dut%0d held pixel", d), p, hold_pix[d]);
    have_hold[d] = plot && !ready;
    hold_pix[d]  = p;
    if (plot && ready) begin
      acc[d].push_back(p);
      last_acc[d] = cyc;
      check($sformatf("dut%0d colour", d), 32'(colour), 7);
      if (q[d].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d extra beat: got %0d, expected none", d, p);
      end else begin
        check($sformatf("dut%0d beat%0d", d, acc[d].size() - 1), p, q[d].pop_front());
      end
    end
    if (done) begin
      done_cnt[d]++;
      done_cyc[d] = cyc;
    end
  endtask

  always @(negedge clk) mon(0, if0.plot, if0.ready, if0.busy, if0.done, if0.x, if0.y, if0.colour);
  always @(negedge clk) mon(1, if1.plot, if1.ready, if1.busy, if1.done, if1.x, if1.y, if1.colour);
  always @(negedge clk) mon(2, if2.plot, if2.ready, if2.busy, if2.done, if2.x, if2.y, if2.colour);

  task automatic push_exp(input int d, input int np, input int bw, input int bh);
    for (int p = 0; p < np; p++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < (c ? 16 : 17); i++)
          for (int dy = 0; dy < bh; dy++)
            for (int dx = 0; dx < bw; dx++)
              q[d].push_back(pix((c ? 43 : 38) + p * 80 + dx, (c ? right_rows[i] : left_rows[i]) + dy));
  endtask

  task automatic set_ready(input int d, input logic v);
    case (d)
      0: if0.ready = v;
      1: if1.ready = v;
      default: if2.ready = v;
    endcase
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: if0.start = v;
      1: if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  function automatic int last_of(input int d);
    if (acc[d].size() == 0) return -1;
    return acc[d][acc[d].size() - 1];
  endfunction

  function automatic int beat_of(input int d, input int b);
    if (acc[d].size() <= b) return -1;
    return acc[d][b];
  endfunction

  task automatic run(input int d, input int np, input int bw, input int bh,
                     input bit rnd, input int budget, input string name);
    int d0;
    d0 = done_cnt[d];
    acc[d].delete();
    push_exp(d, np, bw, bh);
    @(posedge clk); #1 set_start(d, 1'b1);
    @(posedge clk); #1 set_start(d, 1'b0);
    for (int k = 0; k < budget && done_cnt[d] == d0; k++) begin
      @(posedge clk); #1;
      if (rnd) set_ready(d, logic'($urandom_range(0, 1)));
    end
    set_ready(d, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check({name, " done count"}, done_cnt[d] - d0, 1);
    check({name, " beats"}, acc[d].size(), np * 33 * bw * bh);
    check({name, " leftover"}, q[d].size(), 0);
    check({name, " done latency"}, done_cyc[d] - last_acc[d], 1);
    q[d].delete();
  endtask

  initial begin
    int d0;
    tbl[0] = '{0, 38, 4};
    tbl[1] = '{16, 38, 97};
    tbl[2] = '{17, 43, 7};
    tbl[3] = '{33, 118, 4};
    tbl[4] = '{65, 123, 100};
    for (int d = 0; d < 3; d++) begin
      done_cnt[d] = 0; done_cyc[d] = 0; last_acc[d] = 0; have_hold[d] = 0; hold_pix[d] = 0;
    end
    if0.start = 0; if1.start = 0; if2.start = 0;
    if0.ready = 1; if1.ready = 1; if2.ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dut0", {if0.plot, if0.x, if0.y, if0.colour, if0.busy, if0.done}, 0);
    check("reset dut1", {if1.plot, if1.x, if1.y, if1.colour, if1.busy, if1.done}, 0);
    check("reset dut2", {if2.plot, if2.x, if2.y, if2.colour, if2.busy, if2.done}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic repaint with ready held high, plus landmark beats.
    run(0, 2, 1, 1, 1'b0, 300, "basic");
    foreach (tbl[i])
      check($sformatf("landmark beat%0d", tbl[i].beat), beat_of(0, tbl[i].beat),
            pix(tbl[i].x, tbl[i].y));

    // Random backpressure.
    run(0, 2, 1, 1, 1'b1, 1000, "random ready");

    // Start held high: a single repaint, then a fresh rising request repaints again.
    d0 = done_cnt[0];
    acc[0].delete();
    push_exp(0, 2, 1, 1);
    @(posedge clk); #1 if0.start = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("held start dones", done_cnt[0] - d0, 1);
    check("held start beats", acc[0].size(), 66);
    check("held start plot", 32'(if0.plot), 0);
    q[0].delete();
    if0.start = 1'b0;
    repeat (3) @(posedge clk);
    run(0, 2, 1, 1, 1'b0, 300, "second repaint");

    // Reset mid-repaint: no done, clean restart from the origin.
    d0 = done_cnt[0];
    acc[0].delete();
    push_exp(0, 2, 1, 1);
    @(posedge clk); #1 if0.start = 1'b1;
    @(posedge clk); #1 if0.start = 1'b0;
    for (int k = 0; k < 200 && acc[0].size() < 20; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid reset plot", 32'(if0.plot), 0);
    check("mid reset busy", 32'(if0.busy), 0);
    repeat (10) @(posedge clk);
    #1;
    check("mid reset no done", done_cnt[0] - d0, 0);
    check("mid reset plot idle", 32'(if0.plot), 0);
    q[0].delete();
    run(0, 2, 1, 1, 1'b0, 300, "restart");
    check("restart first", beat_of(0, 0), pix(38, 4));

    // 3x3 boxes.
    run(1, 2, 3, 3, 1'b0, 2000, "box3x3");
    check("box3x3 beat8", beat_of(1, 8), pix(40, 6));
    check("box3x3 last", last_of(1), pix(125, 102));

    // Three player lanes.
    run(2, 3, 1, 1, 1'b0, 400, "three lanes");
    check("three lanes beat66", beat_of(2, 66), pix(198, 4));
    check("three lanes last", last_of(2), pix(203, 100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
